st_h2f_return_arbiter: RTL
==========================

Name: st_h2f_return_arbiter

Overview:
- Round-robin burst arbiter that shares the single HPS-bound Avalon-ST sink among N_SRC FPGA-side stream producers.
- The sink is the 32-bit, ready/valid interface feeding the clock-crossing FIFO into the HPS.
- Each grant emits one header word, then a bounded burst of payload words from the winning source.
- HPS software demultiplexes the stream by header.

Parameters:
- N_SRC, 2, number of requesters (1..16).
- LEVEL_W, 10, width of each source fill-level input.
- MAX_BURST, 64, maximum payload words per grant (1..65535).

Ports:
- clk_100_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- enable  in  1  when low, no new grant is issued.
- src_data  in  32*N_SRC  payload; source i occupies bits [32*i+31:32*i].
- src_valid  in  N_SRC  per-source valid.
- src_ready  out  N_SRC  per-source ready.
- src_level  in  LEVEL_W*N_SRC  words currently buffered in source i; source guarantees at least this many words.
- out_data  out  32  to HPS-bound FIFO sink.
- out_valid  out  1  sink valid.
- out_ready  in  1  sink ready.
- busy  out  1  high in HEADER or BURST.
- grant_id  out  4  id of current or last granted source.
- burst_count  out  32  completed bursts, wraps at 2^32.

Behaviour:
- Interface: one clock, clk_100_clk; reset_reset is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, rr pointer 0, remaining count 0. Reset mid-burst aborts immediately, with no header or payload completion.
- Transfer rule: a word moves on valid && ready at a rising edge.
- IDLE:
  - out_valid=0, src_ready=0.
  - Source i is eligible when src_level[i] != 0.
  - If enable=1 and any source is eligible: pick the first eligible source at or after the rr pointer (wrapping modulo N_SRC).
  - Latch grant_id and len = min(src_level[g], MAX_BURST), then go to HEADER.
- HEADER:
  - out_valid=1 and out_data = {8'hA5, grant_id[3:0], 4'h0, len[15:0]}, registered and stable until accepted.
  - src_ready=0.
  - On out_ready: go to BURST with remaining=len.
- BURST:
  - Combinational forward: out_data = src_data[g], out_valid = src_valid[g], src_ready[g] = out_ready. All other src_ready are 0.
  - Each transfer decrements remaining.
  - On the transfer with remaining==1: go to IDLE, set rr pointer = (g+1) mod N_SRC, increment burst_count.
  - If src_valid[g] drops, the block stalls; there is no timeout.
- Latency: IDLE with request → header valid on the next cycle. Back-to-back grants have exactly 1 idle cycle between the last payload beat and the next header.
- Boundaries:
  - enable deasserted in HEADER or BURST: current burst completes; no new grant.
  - src_level changes during a burst: ignored, because len is latched.
  - src_level > MAX_BURST: clipped to MAX_BURST; the remainder is served on a later grant.
  - Only one source eligible: it is re-granted repeatedly.
  - out_ready held low: header and data stay stable.
  - burst_count wraps from 0xFFFFFFFF to 0.
  - N_SRC=1: rr pointer is constant 0.

Decomposition:
- Package st_arb_pkg holds:
  - state enum {IDLE, HEADER, BURST};
  - HDR_SYNC = 8'hA5;
  - header field positions;
  - function min_len.
- One sub-module, rr_pick: combinational first-eligible-at-or-after-pointer priority search, parameterised by N_SRC.

Test Plan:
- Basic burst:
  - Stimulus: N_SRC=2; src_level[0]=3, src1 idle; out_ready=1.
  - Response: header 0xA5000003 one cycle after the request is seen; then 3 src0 words; burst_count=1; rr pointer=1.
- Round-robin fairness:
  - Stimulus: both sources at level 4 continuously.
  - Response: headers alternate 0xA5000004 / 0xA5100004, starting with src0; 1 idle cycle between bursts.
- Clipping:
  - Stimulus: src_level[1]=200, MAX_BURST=64.
  - Response: header 0xA5100040; exactly 64 words; src_ready[1] low afterwards until the next grant.
- Backpressure and stall:
  - Stimulus: out_ready toggles 1/0 each cycle; src_valid gap of 5 cycles mid-burst.
  - Response: no loss or duplication; out_data stable while stalled; word order preserved.
- enable drop:
  - Stimulus: deassert enable during the 2nd payload word of a 4-word burst.
  - Response: burst completes with 4 words; no further header while enable=0.
- Reset mid-burst:
  - Stimulus: assert reset_reset for 1 cycle at word 2 of 5.
  - Response: next cycle out_valid=0, src_ready=0, busy=0, burst_count=0; next grant goes to src0.

Source files
------------

// File: rtl/st_arb_pkg.sv
// Shared types, header layout and helpers for the HPS-bound return-stream arbiter.
package st_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BURST
  } state_t;

  localparam logic [7:0] HDR_SYNC     = 8'hA5;
  localparam int         HDR_SYNC_LSB = 24;
  localparam int         HDR_ID_LSB   = 20;
  localparam int         HDR_LEN_LSB  = 0;

  function automatic logic [15:0] min_len(input logic [31:0] level, input logic [31:0] max_burst);
    if (level < max_burst) return level[15:0];
    return max_burst[15:0];
  endfunction

  // Header word: sync byte, source id, a zero nibble, then the burst length.
  function automatic logic [31:0] make_header(input logic [3:0] id, input logic [15:0] len);
    logic [31:0] h;
    h = '0;
    h[HDR_SYNC_LSB +: 8] = HDR_SYNC;
    h[HDR_ID_LSB +: 4]   = id;
    h[HDR_LEN_LSB +: 16] = len;
    return h;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first eligible requester at or after ptr, wrapping.
module rr_pick #(
  parameter int N_SRC = 2
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [3:0]       ptr,
  output logic [3:0]       pick,
  output logic             any
);

  logic [15:0] elig_pad;
  logic [4:0]  idx;

  always_comb begin
    elig_pad = 16'(eligible);
    pick     = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, ptr} + 5'(k);
      if (idx >= 5'(N_SRC)) idx = idx - 5'(N_SRC);
      if (!any && elig_pad[idx[3:0]]) begin
        any  = 1'b1;
        pick = idx[3:0];
      end
    end
  end

endmodule

// File: rtl/st_h2f_return_arbiter.sv
// Round-robin burst arbiter: one header word then a bounded payload burst per grant,
// sharing the single HPS-bound Avalon-ST sink among N_SRC producers.
module st_h2f_return_arbiter
  import st_arb_pkg::*;
#(
  parameter int N_SRC     = 2,
  parameter int LEVEL_W   = 10,
  parameter int MAX_BURST = 64
) (
  input  logic                     clk_100_clk,
  input  logic                     reset_reset,
  input  logic                     enable,
  input  logic [32*N_SRC-1:0]      src_data,
  input  logic [N_SRC-1:0]         src_valid,
  output logic [N_SRC-1:0]         src_ready,
  input  logic [LEVEL_W*N_SRC-1:0] src_level,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [3:0]               grant_id,
  output logic [31:0]              burst_count
);

  state_t             state;
  logic [3:0]         rr_ptr;
  logic [15:0]        len;
  logic [15:0]        remaining;
  logic [31:0]        header;
  logic [N_SRC-1:0]   eligible;
  logic [3:0]         pick;
  logic               pick_any;
  logic [LEVEL_W-1:0] pick_level;
  logic [15:0]        next_len;
  logic [N_SRC-1:0]   grant_sel;
  logic               grant_valid;
  logic [31:0]        grant_data;
  logic               beat;

  always_comb begin
    eligible   = '0;
    pick_level = '0;
    grant_sel  = '0;
    grant_valid = 1'b0;
    grant_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      eligible[i] = |src_level[LEVEL_W*i +: LEVEL_W];
      if (pick == 4'(i)) pick_level = src_level[LEVEL_W*i +: LEVEL_W];
      if (grant_id == 4'(i)) begin
        grant_sel[i] = 1'b1;
        grant_valid  = src_valid[i];
        grant_data   = src_data[32*i +: 32];
      end
    end
  end

  rr_pick #(
    .N_SRC(N_SRC)
  ) u_rr_pick (
    .eligible(eligible),
    .ptr     (rr_ptr),
    .pick    (pick),
    .any     (pick_any)
  );

  assign next_len = min_len(32'(pick_level), 32'(MAX_BURST));
  assign beat     = (state == BURST) && grant_valid && out_ready;
  assign busy     = (state != IDLE);

  // Length is latched at grant time so level changes mid-burst cannot disturb it.
  always_ff @(posedge clk_100_clk) begin
    if (reset_reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      len         <= '0;
      remaining   <= '0;
      header      <= '0;
      burst_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && pick_any) begin
            grant_id <= pick;
            len      <= next_len;
            header   <= make_header(pick, next_len);
            state    <= HEADER;
          end
        end
        HEADER: begin
          if (out_ready) begin
            remaining <= len;
            state     <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state       <= IDLE;
              rr_ptr      <= (grant_id == 4'(N_SRC - 1)) ? 4'd0 : grant_id + 4'd1;
              burst_count <= burst_count + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload is forwarded straight through so a stalled source simply holds the sink.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    src_ready = '0;
    unique case (state)
      HEADER: begin
        out_valid = 1'b1;
        out_data  = header;
      end
      BURST: begin
        out_valid = grant_valid;
        out_data  = grant_data;
        src_ready = grant_sel & {N_SRC{out_ready}};
      end
      default: ;
    endcase
  end

endmodule
